// File: rtl/morse_key_decoder.sv
// rtl/morse_key_decoder.sv - Morse key level to 5-element code word decoder
module morse_key_decoder #(
   parameter int DOT_MIN  = 1,
   parameter int DASH_MIN = 3,
   parameter int CHAR_GAP = 3,
   parameter int CNT_W    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       key_in,
   output logic [4:0] code_out,
   output logic [2:0] code_len,
   output logic       code_valid,
   output logic       code_err,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MARK  = 2'd1,
      SPACE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] DOT_MIN_C  = DOT_MIN[CNT_W-1:0];
   localparam logic [CNT_W-1:0] DASH_MIN_C = DASH_MIN[CNT_W-1:0];
   localparam logic [CNT_W-1:0] CHAR_GAP_C = CHAR_GAP[CNT_W-1:0];
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [2:0]       MAX_ELEMS  = 3'd5;

   logic             key_m_q;
   logic             key_s_q;
   logic             key_d_q;
   logic             key_rise;
   logic             key_fall;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] mark_cnt_q, mark_cnt_d;
   logic [CNT_W-1:0] space_cnt_q, space_cnt_d;
   logic [CNT_W-1:0] mark_inc;
   logic [CNT_W-1:0] space_inc;
   logic [4:0]       shift_q, shift_d;
   logic [2:0]       idx_q, idx_d;
   logic             ovf_q, ovf_d;
   logic [4:0]       code_out_q, code_out_d;
   logic [2:0]       code_len_q, code_len_d;
   logic             code_valid_q, code_valid_d;
   logic             code_err_q, code_err_d;
   logic             elem_dash;

   // Key synchronizer and edge-detect copy; left running through reset so a key
   // already held down when reset releases is not mistaken for a fresh press.
   always_ff @(posedge clk) begin
      key_m_q <= key_in;
      key_s_q <= key_m_q;
      key_d_q <= key_s_q;
   end

   assign key_rise = key_s_q & ~key_d_q;
   assign key_fall = ~key_s_q & key_d_q;

   // Saturating tick counters; a tick coinciding with a key edge still counts
   // toward the interval being closed.
   always_comb begin
      mark_inc  = mark_cnt_q;
      space_inc = space_cnt_q;
      if (tick && mark_cnt_q != CNT_MAX) begin
         mark_inc = mark_cnt_q + 1'b1;
      end
      if (tick && space_cnt_q != CNT_MAX) begin
         space_inc = space_cnt_q + 1'b1;
      end
   end

   assign elem_dash = (mark_inc >= DASH_MIN_C);

   // State register and all datapath/output flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         mark_cnt_q   <= '0;
         space_cnt_q  <= '0;
         shift_q      <= '0;
         idx_q        <= '0;
         ovf_q        <= 1'b0;
         code_out_q   <= '0;
         code_len_q   <= '0;
         code_valid_q <= 1'b0;
         code_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         mark_cnt_q   <= mark_cnt_d;
         space_cnt_q  <= space_cnt_d;
         shift_q      <= shift_d;
         idx_q        <= idx_d;
         ovf_q        <= ovf_d;
         code_out_q   <= code_out_d;
         code_len_q   <= code_len_d;
         code_valid_q <= code_valid_d;
         code_err_q   <= code_err_d;
      end
   end

   // Next-state: element classification, gap detection and character hand-off.
   always_comb begin
      state_d      = state_q;
      mark_cnt_d   = mark_cnt_q;
      space_cnt_d  = space_cnt_q;
      shift_d      = shift_q;
      idx_d        = idx_q;
      ovf_d        = ovf_q;
      code_out_d   = code_out_q;
      code_len_d   = code_len_q;
      code_valid_d = 1'b0;
      code_err_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (key_rise) begin
               state_d    = MARK;
               mark_cnt_d = '0;
            end
         end

         MARK: begin
            mark_cnt_d = mark_inc;
            if (key_fall) begin
               if (mark_inc < DOT_MIN_C) begin
                  // Glitch: drop it and resume the space already in progress.
                  state_d = (idx_q != 3'd0) ? SPACE : IDLE;
               end else begin
                  if (idx_q < MAX_ELEMS) begin
                     shift_d[idx_q] = elem_dash;
                     idx_d          = idx_q + 3'd1;
                  end else begin
                     ovf_d = 1'b1;
                  end
                  state_d     = SPACE;
                  space_cnt_d = '0;
               end
            end
         end

         SPACE: begin
            space_cnt_d = space_inc;
            // The gap takes priority over a key press landing on the same cycle.
            if (space_cnt_q >= CHAR_GAP_C) begin
               state_d = DONE;
            end else if (key_rise) begin
               state_d    = MARK;
               mark_cnt_d = '0;
            end
         end

         DONE: begin
            if (ovf_q) begin
               code_err_d = 1'b1;
            end else begin
               code_valid_d = 1'b1;
               code_out_d   = shift_q;
               code_len_d   = idx_q;
            end
            shift_d     = '0;
            idx_d       = '0;
            ovf_d       = 1'b0;
            space_cnt_d = '0;
            state_d     = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign code_out   = code_out_q;
   assign code_len   = code_len_q;
   assign code_valid = code_valid_q;
   assign code_err   = code_err_q;
   assign busy       = (state_q == MARK) || (state_q == SPACE);

endmodule

// File: tb/tb_morse_key_decoder.sv
// tb/tb_morse_key_decoder.sv - scoreboard bench for morse_key_decoder
module tb_morse_key_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       key_in = 1'b0;
   logic [4:0] code_out;
   logic [2:0] code_len;
   logic       code_valid;
   logic       code_err;
   logic       busy;

   typedef struct packed {
      logic       err;
      logic [4:0] code;
      logic [2:0] len;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk    = 0;
   int   n_pass   = 0;
   int   n_strobe = 0;
   int   n_pushed = 0;

   morse_key_decoder dut (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .key_in     (key_in),
      .code_out   (code_out),
      .code_len   (code_len),
      .code_valid (code_valid),
      .code_err   (code_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      if (obs === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_pulse();
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
   endtask

   task automatic key_mark(input int n);
      key_in = 1'b1;
      repeat (4) cyc();
      repeat (n) tick_pulse();
      key_in = 1'b0;
      repeat (4) cyc();
   endtask

   task automatic space(input int n);
      repeat (n) tick_pulse();
   endtask

   task automatic push(input logic err, input logic [4:0] code, input logic [2:0] len);
      exp_t e;
      e.err  = err;
      e.code = code;
      e.len  = len;
      exp_q.push_back(e);
      n_pushed++;
   endtask

   // Close a character with a 3-tick space; when a strobe is due, its
   // position relative to the final tick is measured.
   task automatic gap(input logic strobe_due);
      int lat;
      space(2);
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      lat = -1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (lat < 0 && (code_valid || code_err)) lat = k;
      end
      if (strobe_due) chk("strobe_latency", lat, 2);
      cyc();
   endtask

   // Output monitor: every strobe is matched against the scoreboard head.
   always @(negedge clk) begin
      if (!rst && (code_valid || code_err)) begin
         n_strobe++;
         if (exp_q.size() == 0) begin
            chk("unexpected_strobe", {code_valid, code_err}, 2'b00);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("both_strobes", code_valid & code_err, 1'b0);
            chk("strobe_kind_err", code_err, e.err);
            chk("code_out", code_out, e.code);
            chk("code_len", code_len, e.len);
         end
      end
   end

   initial begin
      // Reset with the key already held.
      key_in = 1'b1;
      rst    = 1'b1;
      repeat (5) cyc();
      rst = 1'b0;
      repeat (3) cyc();
      chk("rst_code_out", code_out, 5'd0);
      chk("rst_code_len", code_len, 3'd0);
      chk("rst_code_valid", code_valid, 1'b0);
      chk("rst_code_err", code_err, 1'b0);
      chk("rst_busy", busy, 1'b0);
      key_in = 1'b0;
      repeat (4) cyc();
      gap(1'b0);
      chk("no_press_idle_busy", busy, 1'b0);

      // "R": dot dash dot.
      push(1'b0, 5'b00010, 3'd3);
      key_mark(1); space(1);
      chk("busy_mid_char", busy, 1'b1);
      key_mark(3); space(1);
      key_mark1: key_mark(1);
      gap(1'b1);

      // Five dashes.
      push(1'b0, 5'b11111, 3'd5);
      for (int i = 0; i < 5; i++) begin
         key_mark(3);
         if (i < 4) space(1);
      end
      gap(1'b1);

      // Six dots overflow; previous code word stays on the outputs.
      push(1'b1, 5'b11111, 3'd5);
      for (int i = 0; i < 6; i++) begin
         key_mark(1);
         if (i < 5) space(1);
      end
      gap(1'b1);

      // "I" with a tickless key glitch between the two dots.
      push(1'b0, 5'b00000, 3'd2);
      key_mark(1);
      space(1);
      key_in = 1'b1;
      cyc();
      key_in = 1'b0;
      repeat (4) cyc();
      space(1);
      key_mark(1);
      gap(1'b1);

      // Reset after two elements, then "T".
      key_mark(3); space(1);
      key_mark(1); space(1);
      rst = 1'b1;
      #1;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_code_out", code_out, 5'd0);
      repeat (3) cyc();
      rst = 1'b0;
      repeat (2) cyc();
      push(1'b0, 5'b00001, 3'd1);
      key_mark(3);
      gap(1'b1);

      repeat (5) cyc();
      chk("scoreboard_empty", exp_q.size(), 0);
      chk("strobe_count", n_strobe, n_pushed);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/morse_key_decoder.md
Name: morse_key_decoder

Overview:
- Receive-side counterpart of the beep/tone transmitter: converts a raw Morse key level into a 5-element Morse code word.
- Times key marks and spaces in unit ticks and classifies each mark as dot or dash.
- Detects the inter-character gap and presents the code word with a one-cycle valid strobe to the downstream character lookup/display logic.
- Code-word format matches the transmitter: element k in bit k (bit 0 keyed first), 1 = dash, 0 = dot.

Parameters:
- DOT_MIN, 1, minimum mark length in ticks accepted as an element. Shorter marks are glitches and are discarded.
- DASH_MIN, 3, mark length in ticks at or above which the element is a dash.
- CHAR_GAP, 3, space length in ticks that ends a character.
- CNT_W, 4, width of the mark and space tick counters. Both counters saturate at 2^CNT_W-1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- tick  input  1  one-cycle time-unit strobe, synchronous to clk
- key_in  input  1  raw key level, 1 = pressed; asynchronous to clk
- code_out  output  5  decoded elements, bit k = element k, unused bits 0
- code_len  output  3  number of valid elements, 1..5
- code_valid  output  1  one-cycle strobe; code_out and code_len are valid in this cycle
- code_err  output  1  one-cycle strobe in place of code_valid when the character overflowed (more than 5 elements)
- busy  output  1  high while a character is being assembled (states MARK or SPACE)

Behaviour:
- Input sync: key_in passes through a 2-flop synchronizer, giving key_s. All decisions use key_s. Edge detect compares key_s against its registered copy.
- Reset (asynchronous, active-high): state IDLE; all counters 0; shift/index registers 0; overflow flag 0.
- Reset output values: code_out=0, code_len=0, code_valid=0, code_err=0, busy=0.
- Reset mid-character discards the partial character. No strobe is emitted.
- States:
  - IDLE: on a key_s rising edge go to MARK and clear mark_cnt.
  - MARK: mark_cnt increments on tick (saturating). On a key_s falling edge, classify:
    - mark_cnt < DOT_MIN: glitch. Return to SPACE if idx>0, otherwise IDLE. Element index is unchanged. space_cnt is not cleared, so the space timing continues.
    - DOT_MIN <= mark_cnt < DASH_MIN: dot (0).
    - mark_cnt >= DASH_MIN: dash (1).
    - For a valid element: if idx<5, write bit idx = element value and increment idx; if idx=5, set the overflow flag. Then go to SPACE with space_cnt cleared.
  - SPACE: space_cnt increments on tick (saturating).
    - key_s rising edge before space_cnt reaches CHAR_GAP: go to MARK and clear mark_cnt.
    - space_cnt reaching CHAR_GAP: go to DONE.
  - DONE (one cycle), then IDLE with idx, shift register and overflow flag cleared:
    - No overflow: code_valid=1 with code_out=shift register and code_len=idx.
    - Overflow: code_err=1; code_out and code_len hold their previous values.
- Latency: code_valid rises on the clk edge after the tick that brings space_cnt to CHAR_GAP, i.e. 2 cycles after that tick edge.
- code_out and code_len hold their last values until the next code_valid. The strobes are exactly one cycle wide.
- Simultaneous events:
  - A tick in the same cycle as a key edge counts toward the state being left, then the new counter is cleared.
  - A rising edge in the same cycle that space_cnt reaches CHAR_GAP: the gap wins. Go to DONE; the new mark is lost. Documented limitation; the operator must respect the gap.
- A mark held past saturation (15 ticks) remains a dash. There is no timeout.
- busy = (state==MARK) or (state==SPACE).

Test Plan:
- Reset with key_in=1 held, release reset -> all outputs 0. Key release then gap produces no strobe, since no rising edge was seen after reset.
- Key marks of 1,3,1 ticks separated by 1-tick spaces, then a 3-tick space -> code_valid once, code_out=5'b00010, code_len=3 ("R").
- Marks 3,3,3,3,3 with 1-tick spaces, then gap -> code_out=5'b11111, code_len=5, code_valid once.
- Six 1-tick marks, then gap -> code_err one cycle, code_valid stays 0, code_out unchanged from the previous character.
- Mark of 1 tick, then a 1-cycle key pulse with no tick inside it, then a 1-tick mark, then gap -> glitch ignored; code_out=5'b00000, code_len=2 ("I").
- Assert rst mid-character after 2 elements, release, key a single 3-tick mark and gap -> code_out=5'b00001, code_len=1 ("T"); no stale bits.
